// File: rtl/gray_rx_decoder.sv
// Gray-to-binary receive decoder with single-step legality check and saturating error counter.
// Latency: word accepted at edge k is presented on bin_out after edge k+1 (two register stages).
// Backpressure: valid/ready; two words buffered, in_ready drops only when both stages hold data and out_ready is low.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     input handshake, gray_in carries the gray-coded word
//   out_valid/out_ready   output handshake, bin_out/step_err carry the decoded word and its step flag
//   err_count, clr_err    saturating count of illegal steps and its synchronous clear
module gray_rx_decoder #(
    parameter int N     = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     bin_out,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count,
    input  logic             clr_err
);

    // Stage 1: raw gray word plus its step flag
    logic             s1_valid;
    logic [N-1:0]     s1_gray;
    logic             s1_err;

    // Stage 2: decoded binary word plus its step flag, drives the outputs
    logic             s2_valid;
    logic [N-1:0]     s2_bin;
    logic             s2_err;

    // Reference for the step check: last gray word accepted at the input
    logic             has_ref;
    logic [N-1:0]     last_gray;

    logic [ERR_W-1:0] err_cnt;

    logic             s2_free;
    logic             s1_adv;
    logic             accept;
    logic             step_bad;
    logic [N-1:0]     diff;
    logic [N-1:0]     s1_bin;

    assign s2_free  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;
    assign s1_adv   = s1_valid && s2_free;

    // Clearing the lowest set bit of the difference leaves a non-zero value
    // exactly when two or more bits changed, i.e. Hamming distance >= 2.
    assign diff     = gray_in ^ last_gray;
    assign step_bad = has_ref && ((diff & (diff - N'(1))) != '0);

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        s1_bin        = '0;
        s1_bin[N-1]   = s1_gray[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            s1_bin[i] = s1_bin[i+1] ^ s1_gray[i];
        end
    end

    // Stage 1 register; loading on accept also covers a simultaneous unload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_gray  <= '0;
            s1_err   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_gray  <= gray_in;
            s1_err   <= step_bad;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 register; data only changes on advance so it holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_bin   <= '0;
            s2_err   <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_bin   <= s1_bin;
            s2_err   <= s1_err;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Step reference follows every accepted word, legal or not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            has_ref   <= 1'b0;
            last_gray <= '0;
        end else if (accept) begin
            has_ref   <= 1'b1;
            last_gray <= gray_in;
        end
    end

    // Error counter counts at acceptance; clear wins over an increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else if (accept && step_bad && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

    assign out_valid = s2_valid;
    assign bin_out   = s2_bin;
    assign step_err  = s2_err;
    assign err_count = err_cnt;

endmodule

// File: tb/tb_gray_rx_decoder.sv
module tb_gray_rx_decoder;

    localparam int N     = 8;
    localparam int EW    = 2;
    localparam int CMAX  = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  gray_in;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  bin_out;
    logic          step_err;
    logic [EW-1:0] err_count;
    logic          clr_err;

    int checks   = 0;
    int failures = 0;

    gray_rx_decoder #(.N(N), .ERR_W(EW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gray_in   (gray_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .step_err  (step_err),
        .err_count (err_count),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Words in flight, oldest first. age = edges seen since (and including)
    // the accepting edge; a word is presentable once it has aged two edges.
    typedef struct {
        logic [N-1:0] bin;
        logic         err;
        int           age;
    } ent_t;

    ent_t         mq[$];
    bit           m_ref;
    logic [N-1:0] m_last;
    int           m_cnt;
    bit           started = 0;

    logic [8:0]   seen[$];
    int           acc_seen;

    function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
        logic [N-1:0] b;
        b = g;
        for (int s = 1; s < N; s++) b = b ^ (g >> s);
        return b;
    endfunction

    always @(posedge clk) begin
        ent_t e;
        bit   pop;
        bit   rdy;
        bit   acc;
        bit   bad;
        started = 1;
        if (!rst_n) begin
            mq.delete();
            m_ref  = 0;
            m_last = '0;
            m_cnt  = 0;
        end else begin
            pop = (mq.size() > 0) && (mq[0].age >= 2) && out_ready;
            rdy = (mq.size() < 2) || out_ready;
            acc = in_valid && rdy;
            bad = m_ref && ($countones(gray_in ^ m_last) >= 2);
            if (clr_err) m_cnt = 0;
            else if (acc && bad && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (pop) void'(mq.pop_front());
            foreach (mq[i]) mq[i].age = mq[i].age + 1;
            if (acc) begin
                e.bin = g2b(gray_in);
                e.err = bad;
                e.age = 1;
                mq.push_back(e);
                m_ref  = 1;
                m_last = gray_in;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        bit exp_v;
        if (started) begin
            exp_v = (mq.size() > 0) && (mq[0].age >= 2);
            chk("in_ready", {31'd0, in_ready}, {31'd0, ((mq.size() < 2) || out_ready)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            if (exp_v) begin
                chk("bin_out", {24'd0, bin_out}, {24'd0, mq[0].bin});
                chk("step_err", {31'd0, step_err}, {31'd0, mq[0].err});
            end
            chk("err_count", {30'd0, err_count}, m_cnt);
            if (out_valid && out_ready) seen.push_back({step_err, bin_out});
            if (in_valid && in_ready) acc_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clr_err  = 1'b0;
        gray_in  = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        seen.delete();
        acc_seen = 0;
    endtask

    task automatic push(input logic [N-1:0] w, input logic clr);
        int t;
        t        = 0;
        in_valid = 1'b1;
        gray_in  = w;
        clr_err  = clr;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 100) begin
                chk("push_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        clr_err  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (mq.size() == 0) break;
            t++;
            if (t > 50) begin
                chk("drain_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    task automatic expect_seen(input string nm, input int n,
                               input logic [8:0] e0, input logic [8:0] e1,
                               input logic [8:0] e2, input logic [8:0] e3);
        logic [8:0] ex[4];
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        chk({nm, "_count"}, seen.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < seen.size()) chk(nm, {23'd0, seen[i]}, {23'd0, ex[i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        gray_in   = '0;
        out_ready = 1'b1;
        clr_err   = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_bin_out",   {24'd0, bin_out},   32'd0);
        chk("rst_step_err",  {31'd0, step_err},  32'd0);
        chk("rst_err_count", {30'd0, err_count}, 32'd0);

        // Streaming decode
        @(posedge clk); #2;
        push(8'h00, 1'b0); push(8'h01, 1'b0); push(8'h03, 1'b0); push(8'h02, 1'b0);
        drain();
        expect_seen("stream", 4, 9'h000, 9'h001, 9'h002, 9'h003);
        chk("stream_cnt", {30'd0, err_count}, 32'd0);

        // Illegal step then legal recovery
        do_reset();
        push(8'h00, 1'b0); push(8'h03, 1'b0);
        chk("illegal_cnt", {30'd0, err_count}, 32'd1);
        push(8'h02, 1'b0);
        drain();
        expect_seen("illegal", 3, 9'h000, 9'h102, 9'h003, 9'h000);

        // Wrap-around and repeated word
        do_reset();
        push(8'h80, 1'b0); push(8'h80, 1'b0); push(8'h00, 1'b0);
        drain();
        expect_seen("wrap", 3, 9'h0FF, 9'h0FF, 9'h000, 9'h000);
        chk("wrap_cnt", {30'd0, err_count}, 32'd0);

        // Backpressure: two words buffered, then release
        do_reset();
        out_ready = 1'b0;
        fork
            begin
                push(8'h00, 1'b0); push(8'h01, 1'b0); push(8'h03, 1'b0); push(8'h02, 1'b0);
            end
        join_none
        repeat (4) @(negedge clk);
        chk("bp_stable_a", {24'd0, bin_out}, 32'h00);
        repeat (2) @(negedge clk);
        chk("bp_accepts",  acc_seen, 32'd2);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_stable_b", {24'd0, bin_out}, 32'h00);
        @(posedge clk); #2;
        out_ready = 1'b1;
        wait fork;
        drain();
        expect_seen("bp", 4, 9'h000, 9'h001, 9'h002, 9'h003);

        // Saturation and clear priority
        do_reset();
        push(8'h00, 1'b0);
        push(8'h03, 1'b0); push(8'h00, 1'b0); push(8'h03, 1'b0);
        push(8'h00, 1'b0); push(8'h03, 1'b0);
        chk("sat_cnt", {30'd0, err_count}, 32'd3);
        push(8'h00, 1'b1);
        chk("clr_cnt", {30'd0, err_count}, 32'd0);
        push(8'h03, 1'b0);
        chk("post_clr_cnt", {30'd0, err_count}, 32'd1);
        drain();

        // Reset mid-stream
        do_reset();
        out_ready = 1'b0;
        push(8'h00, 1'b0); push(8'h03, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_cnt",   {30'd0, err_count}, 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid",    {31'd0, out_valid}, 32'd0);
        chk("mid_rst_cnt",      {30'd0, err_count}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready},  32'd1);
        seen.delete();
        @(posedge clk); #2;
        out_ready = 1'b1;
        push(8'h55, 1'b0);
        drain();
        expect_seen("after_rst", 1, 9'h066, 9'h000, 9'h000, 9'h000);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
